// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C constants for the master and receiver_I2C.
// State codes, SCL phase indices, ACK levels and default divider.
package i2c_pkg;

  localparam int DIV_FREQ_DEF = 2;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WR_BYTE  = 4'd4;
  localparam logic [3:0] S_WR_ACK   = 4'd5;
  localparam logic [3:0] S_RD_BYTE  = 4'd6;
  localparam logic [3:0] S_RD_ACK   = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_LOW1  = 2'd1;
  localparam logic [1:0] PH_HIGH0 = 2'd2;
  localparam logic [1:0] PH_HIGH1 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_transmitter_if.sv
// i2c_transmitter_if: CPU request/response and I2C pin bundle.
// master = transmitter side, slave = CPU plus bus-slave side.
interface i2c_transmitter_if;

  logic        START_STB;
  logic        RNW;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA;
  logic        SDA_IN;
  logic        SCL;
  logic        SDA_OUT;
  logic        SDA_OE;
  logic [15:0] RD_DATA;
  logic        BUSY;
  logic        DONE;
  logic        NACK;

  modport master (
    input  START_STB, RNW, I2C_ADDR, WR_DATA, SDA_IN,
    output SCL, SDA_OUT, SDA_OE, RD_DATA, BUSY, DONE, NACK
  );

  modport slave (
    output START_STB, RNW, I2C_ADDR, WR_DATA, SDA_IN,
    input  SCL, SDA_OUT, SDA_OE, RD_DATA, BUSY, DONE, NACK
  );

endinterface

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: prescaler with 2-bit phase in its top bits.
// Gives next-cycle phase/level plus sample and end-of-slot strobes.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_FREQ = DIV_FREQ_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic       lvl_o,
  output logic [1:0] ph_o,
  output logic       smp_o,
  output logic       eos_o
);

  localparam int Q = 1 << (DIV_FREQ - 2);
  localparam logic [DIV_FREQ-1:0] SMP_CNT = DIV_FREQ'(3 * Q - 1);
  localparam logic [DIV_FREQ-1:0] EOS_CNT = DIV_FREQ'(4 * Q - 1);

  logic [DIV_FREQ-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + DIV_FREQ'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign ph_o  = cnt_d[DIV_FREQ-1 -: 2];
  assign lvl_o = (ph_o == PH_HIGH0) || (ph_o == PH_HIGH1);
  assign smp_o = run_i && (cnt_q == SMP_CNT);
  assign eos_o = run_i && (cnt_q == EOS_CNT);

endmodule

// File: rtl/i2c_transmitter.sv
// i2c_transmitter: I2C master for START/addr/2 data bytes/STOP.
// clk, rst (async low), bus (i2c_transmitter_if.master).
module i2c_transmitter
  import i2c_pkg::*;
#(
  parameter int DIV_FREQ = DIV_FREQ_DEF
) (
  input logic               clk,
  input logic               rst,
  i2c_transmitter_if.master bus
);

  logic [3:0]  state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic        byte_q, byte_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] wr_q, wr_d;
  logic [15:0] rx_q, rx_d;
  logic        rnw_q, rnw_d;
  logic        abort_q, abort_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        oe_q, oe_d;
  logic [15:0] rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;

  logic        run, lvl, smp, eos;
  logic [1:0]  ph;

  assign run = (state_q != S_IDLE);

  i2c_scl_gen #(
    .DIV_FREQ(DIV_FREQ)
  ) u_scl (
    .clk   (clk),
    .rst   (rst),
    .run_i (run),
    .lvl_o (lvl),
    .ph_o  (ph),
    .smp_o (smp),
    .eos_o (eos)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    wr_d    = wr_q;
    rx_d    = rx_q;
    rnw_d   = rnw_q;
    abort_d = abort_q;
    rd_d    = rd_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START_STB) begin
          state_d = S_START;
          tx_d    = {bus.I2C_ADDR, bus.RNW};
          rnw_d   = bus.RNW;
          wr_d    = bus.WR_DATA;
          abort_d = 1'b0;
          nack_d  = 1'b0;
          bit_d   = 3'd0;
          byte_d  = 1'b0;
        end
      end
      S_START: begin
        if (eos) state_d = S_ADDR;
      end
      S_ADDR, S_WR_BYTE: begin
        if (eos) begin
          bit_d = bit_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7)
            state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
        end
      end
      S_ADDR_ACK: begin
        if (smp && bus.SDA_IN == I2C_NACK) abort_d = 1'b1;
        if (eos) begin
          if (abort_q) begin
            state_d = S_STOP;
          end else if (rnw_q) begin
            state_d = S_RD_BYTE;
          end else begin
            state_d = S_WR_BYTE;
            tx_d    = wr_q[15:8];
          end
        end
      end
      S_WR_ACK: begin
        if (smp && bus.SDA_IN == I2C_NACK) abort_d = 1'b1;
        if (eos) begin
          if (abort_q || byte_q) begin
            state_d = S_STOP;
          end else begin
            state_d = S_WR_BYTE;
            byte_d  = 1'b1;
            tx_d    = wr_q[7:0];
          end
        end
      end
      S_RD_BYTE: begin
        if (smp) rx_d = {rx_q[14:0], bus.SDA_IN};
        if (eos) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_RD_ACK;
        end
      end
      S_RD_ACK: begin
        if (eos) begin
          if (byte_q) begin
            state_d = S_STOP;
            rd_d    = rx_q;
          end else begin
            state_d = S_RD_BYTE;
            byte_d  = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (eos) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          nack_d  = abort_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins decode from next state/phase so they land registered in-slot.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    oe_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    unique case (1'b1)
      (state_d == S_START): begin
        scl_d = ~lvl;
        sda_d = 1'b0;
      end
      (state_d == S_ADDR),
      (state_d == S_WR_BYTE): begin
        scl_d = lvl;
        sda_d = tx_d[7];
      end
      (state_d == S_ADDR_ACK),
      (state_d == S_WR_ACK),
      (state_d == S_RD_BYTE): begin
        scl_d = lvl;
        oe_d  = 1'b0;
      end
      (state_d == S_RD_ACK): begin
        scl_d = lvl;
        sda_d = byte_d;
      end
      (state_d == S_STOP): begin
        scl_d = lvl;
        sda_d = (ph == PH_HIGH1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      tx_q    <= 8'd0;
      wr_q    <= 16'd0;
      rx_q    <= 16'd0;
      rnw_q   <= 1'b0;
      abort_q <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b1;
      rd_q    <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rx_q    <= rx_d;
      rnw_q   <= rnw_d;
      abort_q <= abort_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  assign bus.SCL     = scl_q;
  assign bus.SDA_OUT = sda_q;
  assign bus.SDA_OE  = oe_q;
  assign bus.RD_DATA = rd_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.NACK    = nack_q;

endmodule

// File: tb/tb_i2c_transmitter.sv
// tb_i2c_transmitter: slave-side model driving i2c_transmitter.
// Builds the expected slot list per transaction and checks pins.
module tb_i2c_transmitter;
  import i2c_pkg::*;

  localparam int K_START = 0;
  localparam int K_TX    = 1;
  localparam int K_SACK  = 2;
  localparam int K_RX    = 3;
  localparam int K_MACK  = 4;
  localparam int K_STOP  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  i2c_transmitter_if bus();

  i2c_transmitter #(
    .DIV_FREQ(DIV_FREQ_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; raises START_STB in that cycle.
  task automatic run_txn(input logic [6:0]  addr,
                         input logic        rnw,
                         input logic [15:0] wd,
                         input logic [15:0] rd,
                         input int          nak_at,
                         input bit          glitch);
    int   kind[$];
    bit   val[$];
    logic [7:0] ab;
    logic scl_a [1:200];
    logic sda_a [1:200];
    logic oe_a  [1:200];
    int   done_n;
    int   s;
    int   n0;
    bit   aborted;
    logic [3:0] g_scl, g_sda, g_oe, e_scl, e_sda, e_oe;

    ab = {addr, rnw};
    kind.push_back(K_START); val.push_back(1'b0);
    for (int i = 7; i >= 0; i--) begin
      kind.push_back(K_TX); val.push_back(ab[i]);
    end
    aborted = (nak_at == 0);
    kind.push_back(K_SACK); val.push_back(aborted);
    for (int b = 0; b < 2; b++) begin
      if (!aborted) begin
        for (int i = 7; i >= 0; i--) begin
          kind.push_back(rnw ? K_RX : K_TX);
          val.push_back(rnw ? rd[(1-b)*8+i] : wd[(1-b)*8+i]);
        end
        if (rnw) begin
          kind.push_back(K_MACK); val.push_back(b == 1);
        end else begin
          aborted = (nak_at == b + 1);
          kind.push_back(K_SACK); val.push_back(aborted);
        end
      end
    end
    kind.push_back(K_STOP); val.push_back(1'b0);
    if (rnw && !aborted) exp_rd = rd;

    bus.I2C_ADDR  = addr;
    bus.RNW       = rnw;
    bus.WR_DATA   = wd;
    bus.START_STB = 1'b1;
    @(posedge clk); #1;
    bus.START_STB = 1'b0;
    done_n = 0;
    for (int n = 1; n <= 200; n++) begin
      s = (n - 1) / 4;
      bus.SDA_IN = 1'b1;
      if (s < kind.size() && (kind[s] == K_SACK || kind[s] == K_RX))
        bus.SDA_IN = val[s];
      if (glitch && (n == 20 || n == 60)) begin
        bus.START_STB = 1'b1;
        bus.WR_DATA   = 16'($urandom);
        bus.I2C_ADDR  = 7'($urandom);
        bus.RNW       = 1'($urandom);
      end else begin
        bus.START_STB = 1'b0;
      end
      @(negedge clk);
      scl_a[n] = bus.SCL;
      sda_a[n] = bus.SDA_OUT;
      oe_a[n]  = bus.SDA_OE;
      if (n == 1) begin
        chk("busy_start", 32'(bus.BUSY), 32'd1);
        chk("nack_clear", 32'(bus.NACK), 32'd0);
      end
      if (bus.DONE) begin
        done_n = n;
        break;
      end
      @(posedge clk); #1;
    end
    bus.START_STB = 1'b0;

    chk("done_cycle", 32'(done_n), 32'(4 * kind.size() + 1));
    if (done_n > 0) begin
      chk("busy_done", 32'(bus.BUSY), 32'd0);
      chk("nack", 32'(bus.NACK), 32'(aborted));
      chk("rd_data", 32'(bus.RD_DATA), 32'(exp_rd));
      chk("idle_bus", 32'({bus.SCL, bus.SDA_OUT, bus.SDA_OE}), 32'd7);
    end

    for (int k = 0; k < kind.size(); k++) begin
      for (int c = 0; c < 4; c++) begin
        n0 = 4 * k + 1 + c;
        g_scl[3-c] = scl_a[n0];
        g_sda[3-c] = sda_a[n0];
        g_oe[3-c]  = oe_a[n0];
      end
      e_scl = 4'b0011;
      e_sda = {4{val[k]}};
      e_oe  = 4'b1111;
      case (kind[k])
        K_START: begin e_scl = 4'b1100; e_sda = 4'b0000; end
        K_STOP:  e_sda = 4'b0001;
        K_SACK, K_RX: begin
          e_oe  = 4'b0000;
          e_sda = 4'b0000;
          g_sda = 4'b0000;
        end
        default: ;
      endcase
      chk($sformatf("slot%0d_kind%0d", k, kind[k]),
          32'({g_scl, g_sda, g_oe}), 32'({e_scl, e_sda, e_oe}));
    end
  endtask

  task automatic gap();
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.DONE), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dcnt;
    int nk;
    logic r;
    bus.START_STB = 1'b0;
    bus.RNW       = 1'b0;
    bus.I2C_ADDR  = 7'd0;
    bus.WR_DATA   = 16'd0;
    bus.SDA_IN    = 1'b1;
    exp_rd        = 16'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(bus.SCL), 32'd1);
    chk("rst_sda", 32'(bus.SDA_OUT), 32'd1);
    chk("rst_oe", 32'(bus.SDA_OE), 32'd1);
    chk("rst_rd", 32'(bus.RD_DATA), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_nack", 32'(bus.NACK), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(7'h2A, 1'b0, 16'hA55A, 16'h0000, -1, 1'b0); gap();
    run_txn(7'h2A, 1'b1, 16'h0000, 16'hC33C, -1, 1'b0); gap();
    run_txn(7'h2A, 1'b1, 16'h0000, 16'h1234, 0, 1'b0);  gap();

    // Reset during RD_BYTE: immediate reset outputs, no DONE.
    bus.I2C_ADDR  = 7'h2A;
    bus.RNW       = 1'b1;
    bus.SDA_IN    = 1'b0;
    bus.START_STB = 1'b1;
    @(posedge clk); #1;
    bus.START_STB = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(bus.BUSY), 32'd1);
    chk("pre_rst_oe", 32'(bus.SDA_OE), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(bus.SCL), 32'd1);
    chk("mid_rst_sda", 32'(bus.SDA_OUT), 32'd1);
    chk("mid_rst_oe", 32'(bus.SDA_OE), 32'd1);
    chk("mid_rst_rd", 32'(bus.RD_DATA), 32'd0);
    chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    exp_rd = 16'd0;
    dcnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (i == 10) rst = 1'b1;
      if (bus.DONE) dcnt++;
    end
    chk("no_done_after_rst", 32'(dcnt), 32'd0);
    bus.SDA_IN = 1'b1;

    run_txn(7'h55, 1'b0, 16'hBEEF, 16'h0000, 1, 1'b0); gap();
    run_txn(7'h11, 1'b0, 16'h0F0F, 16'h0000, 2, 1'b0); gap();
    run_txn(7'h3C, 1'b0, 16'h1357, 16'h0000, -1, 1'b1);
    run_txn(7'h4B, 1'b1, 16'h0000, 16'h9AE1, -1, 1'b1);
    gap();

    for (int t = 0; t < 6; t++) begin
      r  = 1'($urandom);
      nk = $urandom_range(0, 4);
      if (nk > 2) nk = -1;
      run_txn(7'($urandom), r, 16'($urandom), 16'($urandom), nk, 1'b0);
      gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
